// File: rtl/interrupt_ctrl.sv
// Machine-mode interrupt controller: registers MEIP/MTIP/MSIP, prioritises and hands one trap
// at a time to the pipeline. Define IRQ_SYNC_EN to add a 2-flop synchronizer on ext_irq.
module interrupt_ctrl #(
  parameter logic [31:0] MIP_MASK = 32'h0000_0888
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mie,
  input  logic        mstatus_mie,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        sw_irq,
  input  logic        irq_ack,
  input  logic        mret,
  output logic [31:0] mip,
  output logic        irq_req,
  output logic [31:0] irq_cause,
  output logic        irq_active
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] TRAP = 2'd2;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  logic        ext_src;
  logic        ext_pend_q, tmr_pend_q, sw_pend_q;
  logic [31:0] pend_vec;
  logic [31:0] eligible;
  logic [31:0] win_cause;
  logic [1:0]  state_q, state_d;
  logic [31:0] cause_q, cause_d;

`ifdef IRQ_SYNC_EN
  logic [1:0] ext_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_sync_q <= 2'b00;
    end else begin
      ext_sync_q <= {ext_sync_q[0], ext_irq};
    end
  end

  assign ext_src = ext_sync_q[1];
`else
  assign ext_src = ext_irq;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_pend_q <= 1'b0;
      tmr_pend_q <= 1'b0;
      sw_pend_q  <= 1'b0;
    end else begin
      ext_pend_q <= ext_src;
      tmr_pend_q <= timer_irq;
      sw_pend_q  <= sw_irq;
    end
  end

  always_comb begin
    pend_vec     = '0;
    pend_vec[11] = ext_pend_q;
    pend_vec[7]  = tmr_pend_q;
    pend_vec[3]  = sw_pend_q;
  end

  assign mip      = pend_vec & MIP_MASK;
  assign eligible = mip & mie & {32{mstatus_mie}};

  // Fixed priority: MSI deliberately ranks above MTI.
  always_comb begin
    win_cause = CAUSE_MTI;
    if (eligible[11]) begin
      win_cause = CAUSE_MEI;
    end else if (eligible[3]) begin
      win_cause = CAUSE_MSI;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          state_d = REQ;
          cause_d = win_cause;
        end
      end
      REQ: begin
        // Ack wins over a simultaneous withdrawal.
        if (irq_ack) begin
          state_d = TRAP;
        end else if (eligible == '0) begin
          state_d = IDLE;
        end
      end
      TRAP: begin
        if (mret) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign irq_active = (state_q == TRAP);
  assign irq_cause  = cause_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: directed vector table, hand sequences for ext latency and async
// reset, then random stimulus against a cycle-level reference model.
module tb_interrupt_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int EXT_LAT = 3;
`else
  localparam int EXT_LAT = 1;
`endif
  localparam logic [31:0] MASK = 32'h0000_0888;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mie = '0;
  logic        mstatus_mie = 1'b0;
  logic        ext_irq = 1'b0;
  logic        timer_irq = 1'b0;
  logic        sw_irq = 1'b0;
  logic        irq_ack = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] mip;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic        irq_active;

  interrupt_ctrl #(.MIP_MASK(MASK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mie        (mie),
    .mstatus_mie(mstatus_mie),
    .ext_irq    (ext_irq),
    .timer_irq  (timer_irq),
    .sw_irq     (sw_irq),
    .irq_ack    (irq_ack),
    .mret       (mret),
    .mip        (mip),
    .irq_req    (irq_req),
    .irq_cause  (irq_cause),
    .irq_active (irq_active)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] mie;
    logic        gmie, tmr, sw, ack, mret;
    logic [31:0] e_mip;
    logic        e_req;
    logic [31:0] e_cause;
    logic        e_act;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] m, input logic g, input logic t, input logic s,
                              input logic a, input logic r, input logic [31:0] em,
                              input logic eq, input logic [31:0] ec, input logic ea);
    vec_t v;
    v.mie = m; v.gmie = g; v.tmr = t; v.sw = s; v.ack = a; v.mret = r;
    v.e_mip = em; v.e_req = eq; v.e_cause = ec; v.e_act = ea;
    return v;
  endfunction

  // Reference model: pending bits are input samples delayed by their latency; the handshake is
  // tracked as two flags (request outstanding, handler running).
  logic [31:0] m_mip;
  logic        m_req, m_trap;
  logic [31:0] m_cause;
  logic [2:0]  ext_hist;

  function automatic logic [31:0] pick(input logic [31:0] e);
    if (e[11]) return 32'h8000_000B;
    if (e[3])  return 32'h8000_0003;
    return 32'h8000_0007;
  endfunction

  task automatic model_reset();
    m_mip = '0; m_req = 0; m_trap = 0; m_cause = '0; ext_hist = '0;
  endtask

  task automatic model_step();
    logic [31:0] elig, nm;
    elig = m_mip & mie & {32{mstatus_mie}};
    if (!m_req && !m_trap) begin
      if (elig != 0) begin m_req = 1; m_cause = pick(elig); end
    end else if (m_req) begin
      if (irq_ack) begin m_req = 0; m_trap = 1; end
      else if (elig == 0) m_req = 0;
    end else if (mret) begin
      m_trap = 0;
    end
    ext_hist = {ext_hist[1:0], ext_irq};
    nm = '0;
    nm[11] = ext_hist[EXT_LAT-1];
    nm[7] = timer_irq;
    nm[3] = sw_irq;
    m_mip = nm & MASK;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0; mie = '0; mstatus_mie = 0; ext_irq = 0; timer_irq = 0; sw_irq = 0;
    irq_ack = 0; mret = 0;
    edge_wait();
    rst_n = 1;
  endtask

  vec_t tbl[20];

  initial begin
    tbl[0]  = mk(32'h080, 1, 1, 0, 0, 0, 32'h080, 0, 32'h0,         0);
    tbl[1]  = mk(32'h080, 1, 1, 0, 0, 0, 32'h080, 1, 32'h8000_0007, 0);
    tbl[2]  = mk(32'h080, 1, 1, 0, 1, 0, 32'h080, 0, 32'h8000_0007, 1);
    tbl[3]  = mk(32'h088, 1, 1, 1, 0, 0, 32'h088, 0, 32'h8000_0007, 1);
    tbl[4]  = mk(32'h088, 1, 1, 1, 0, 1, 32'h088, 0, 32'h8000_0007, 0);
    tbl[5]  = mk(32'h088, 1, 1, 1, 0, 0, 32'h088, 1, 32'h8000_0003, 0);
    tbl[6]  = mk(32'h000, 1, 1, 1, 0, 0, 32'h088, 0, 32'h8000_0003, 0);
    tbl[7]  = mk(32'h080, 1, 1, 0, 0, 0, 32'h080, 1, 32'h8000_0007, 0);
    tbl[8]  = mk(32'h000, 1, 1, 0, 1, 0, 32'h080, 0, 32'h8000_0007, 1);
    tbl[9]  = mk(32'h000, 1, 0, 0, 0, 1, 32'h000, 0, 32'h8000_0007, 0);
    tbl[10] = mk(32'h008, 1, 0, 1, 0, 0, 32'h008, 0, 32'h8000_0007, 0);
    tbl[11] = mk(32'h888, 1, 1, 1, 0, 0, 32'h088, 1, 32'h8000_0003, 0);
    tbl[12] = mk(32'h888, 1, 1, 1, 0, 0, 32'h088, 1, 32'h8000_0003, 0);
    tbl[13] = mk(32'h888, 1, 1, 1, 1, 0, 32'h088, 0, 32'h8000_0003, 1);
    tbl[14] = mk(32'h888, 1, 1, 1, 1, 0, 32'h088, 0, 32'h8000_0003, 1);
    tbl[15] = mk(32'h888, 1, 1, 1, 0, 1, 32'h088, 0, 32'h8000_0003, 0);
    tbl[16] = mk(32'h888, 1, 1, 1, 0, 0, 32'h088, 1, 32'h8000_0003, 0);
    tbl[17] = mk(32'h888, 1, 1, 1, 0, 1, 32'h088, 1, 32'h8000_0003, 0);
    tbl[18] = mk(32'h888, 0, 0, 0, 0, 0, 32'h000, 0, 32'h8000_0003, 0);
    tbl[19] = mk(32'h888, 0, 0, 0, 1, 0, 32'h000, 0, 32'h8000_0003, 0);

    // Reset state, held before any clock edge.
    #2;
    chk("reset mip", mip, 32'h0);
    chk("reset req", {31'b0, irq_req}, 32'h0);
    chk("reset cause", irq_cause, 32'h0);
    chk("reset active", {31'b0, irq_active}, 32'h0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 20; i++) begin
      mie = tbl[i].mie; mstatus_mie = tbl[i].gmie; timer_irq = tbl[i].tmr;
      sw_irq = tbl[i].sw; irq_ack = tbl[i].ack; mret = tbl[i].mret;
      edge_wait();
      chk($sformatf("vec%0d mip", i), mip, tbl[i].e_mip);
      chk($sformatf("vec%0d req", i), {31'b0, irq_req}, {31'b0, tbl[i].e_req});
      chk($sformatf("vec%0d cause", i), irq_cause, tbl[i].e_cause);
      chk($sformatf("vec%0d active", i), {31'b0, irq_active}, {31'b0, tbl[i].e_act});
    end

    // External line latency through the pending flop (and synchronizer if built in).
    do_reset();
    mie = 32'h800; mstatus_mie = 1; ext_irq = 1;
    for (int k = 1; k <= EXT_LAT + 1; k++) begin
      edge_wait();
      chk($sformatf("ext edge%0d mip11", k), {31'b0, mip[11]}, {31'b0, k >= EXT_LAT});
      chk($sformatf("ext edge%0d req", k), {31'b0, irq_req}, {31'b0, k >= EXT_LAT + 1});
    end
    chk("ext cause", irq_cause, 32'h8000_000B);

    // Async reset while a request is outstanding.
    #2 rst_n = 0;
    #1;
    chk("rst midreq req", {31'b0, irq_req}, 32'h0);
    chk("rst midreq mip", mip, 32'h0);
    chk("rst midreq active", {31'b0, irq_active}, 32'h0);
    chk("rst midreq cause", irq_cause, 32'h0);
    @(negedge clk);

    // All three sources raised together.
    do_reset();
    mie = 32'h888; mstatus_mie = 1; ext_irq = 1; timer_irq = 1; sw_irq = 1;
    edge_wait();
    edge_wait();
    chk("all3 req", {31'b0, irq_req}, 32'h1);
    chk("all3 cause", irq_cause, (EXT_LAT == 1) ? 32'h8000_000B : 32'h8000_0003);
    irq_ack = 1;
    edge_wait();
    irq_ack = 0;
    chk("all3 trap", {31'b0, irq_active}, 32'h1);

    // Async reset while the handler runs.
    #2 rst_n = 0;
    #1;
    chk("rst midtrap active", {31'b0, irq_active}, 32'h0);
    chk("rst midtrap mip", mip, 32'h0);
    @(negedge clk);

    // Random stimulus against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 5))
        0: mie = 32'h000;
        1: mie = 32'h008;
        2: mie = 32'h080;
        3: mie = 32'h800;
        4: mie = 32'h888;
        default: mie = $urandom & 32'hFFF;
      endcase
      mstatus_mie = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) ext_irq = ~ext_irq;
      if ($urandom_range(0, 3) == 0) timer_irq = ~timer_irq;
      if ($urandom_range(0, 3) == 0) sw_irq = ~sw_irq;
      irq_ack = ($urandom_range(0, 3) == 0);
      mret = ($urandom_range(0, 3) == 0);
      model_step();
      edge_wait();
      chk($sformatf("rand%0d mip", c), mip, m_mip);
      chk($sformatf("rand%0d req", c), {31'b0, irq_req}, {31'b0, m_req});
      chk($sformatf("rand%0d cause", c), irq_cause, m_cause);
      chk($sformatf("rand%0d active", c), {31'b0, irq_active}, {31'b0, m_trap});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter MIP_MASK, default 32'h0000_0888, which sets the implemented mip bits (MEIP/MTIP/MSIP).
REQ-002 SHALL have port clk  in  1  system clock.
REQ-003 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port mie  in  32  machine interrupt-enable CSR value.
REQ-005 SHALL have port mstatus_mie  in  1  global machine interrupt enable.
REQ-006 SHALL have port ext_irq  in  1  external interrupt line; level, asynchronous to clk.
REQ-007 SHALL have port timer_irq  in  1  timer interrupt line; level, synchronous.
REQ-008 SHALL have port sw_irq  in  1  software interrupt line; level, synchronous.
REQ-009 SHALL have port irq_ack  in  1  pipeline accepts trap; single-cycle pulse.
REQ-010 SHALL have port mret  in  1  handler return; single-cycle pulse.
REQ-011 SHALL have port mip  out  32  machine interrupt-pending CSR value.
REQ-012 SHALL have port irq_req  out  1  interrupt request to pipeline.
REQ-013 SHALL have port irq_cause  out  32  mcause value for the request.
REQ-014 SHALL have port irq_active  out  1  handler in progress.

Function
REQ-015 SHALL register the pending bits: mip[11] from ext_irq (see REQ-030), mip[7] from timer_irq, and mip[3] from sw_irq, each with a 1-cycle flop; all other bits SHALL be 0; mip SHALL be the registered bits ANDed with MIP_MASK.
REQ-016 SHALL form eligible = mip & mie & {32{mstatus_mie}}.
REQ-017 SHALL select by fixed priority MEI (bit 11) > MSI (bit 3) > MTI (bit 7); causes are 32'h8000_000B, 32'h8000_0003, 32'h8000_0007.
REQ-018 SHALL implement the FSM states IDLE, REQ and TRAP.
REQ-019 IDLE -> REQ at the clock edge where eligible != 0; irq_cause SHALL be loaded with the winning cause at that same edge.
REQ-020 In REQ, irq_req = 1 and irq_cause SHALL stay frozen, even if a higher-priority source becomes eligible.
REQ-021 REQ -> TRAP on irq_ack = 1; irq_req SHALL be 0 from the next cycle.
REQ-022 REQ -> IDLE when eligible == 0 and irq_ack = 0 (withdrawal); if withdrawal and irq_ack occur in the same cycle, ack SHALL win and the next state SHALL be TRAP.
REQ-023 In TRAP, irq_active = 1 and irq_req = 0; new eligible sources SHALL be ignored, with no nesting.
REQ-024 TRAP -> IDLE on mret = 1; from IDLE a still-eligible source SHALL raise irq_req again after 1 further cycle.
REQ-025 irq_ack outside REQ and mret outside TRAP SHALL be ignored, with no state change.
REQ-026 Latency: timer_irq/sw_irq high before edge N -> mip bit set after edge N -> irq_req = 1 after edge N+1.
REQ-027 irq_cause SHALL hold its last value in IDLE and TRAP.

Reset
REQ-028 SHALL, with rst_n = 0 (asynchronous, including mid-REQ or mid-TRAP), force the FSM to IDLE and all pending and synchronizer flops to 0.
REQ-029 SHALL, during reset, output mip = 0, irq_req = 0, irq_cause = 0 and irq_active = 0.

Configuration
REQ-030 With macro IRQ_SYNC_EN defined, ext_irq SHALL pass through a 2-flop synchronizer ahead of the mip[11] flop, so mip[11] rises 3 edges after ext_irq; without it, ext_irq SHALL feed the mip[11] flop directly (1 edge), like timer_irq.

Verification
REQ-031 mie = 32'h80, mstatus_mie = 1, timer_irq = 1 -> mip = 32'h80 after edge 1, irq_req = 1 with irq_cause = 32'h8000_0007 after edge 2; irq_ack pulse -> irq_req = 0, irq_active = 1.
REQ-032 mie = 32'h888, ext_irq, sw_irq and timer_irq raised in the same cycle, IRQ_SYNC_EN undefined -> irq_cause = 32'h8000_000B.
REQ-033 In REQ with cause 32'h8000_0007, clear mie to 0 with no ack -> IDLE next cycle, irq_req = 0; repeat the scenario with irq_ack in the same cycle -> TRAP.
REQ-034 In TRAP, pulse sw_irq with mie[3] = 1 -> irq_req stays 0; pulse mret while sw_irq is held -> irq_req = 1 two cycles later with cause 32'h8000_0003.
REQ-035 Assert rst_n = 0 mid-REQ -> irq_req, irq_active and mip become 0 immediately, with no clock edge needed.
REQ-036 IRQ_SYNC_EN defined, ext_irq = 1 with mie[11] = 1 -> mip[11] = 1 after edge 3, irq_req = 1 after edge 4.
